// File: rtl/feed_pkt_buffer.sv
// Store-and-forward packet buffer: beats are written speculatively, committed on a clean eop and
// rolled back on error, overflow or abort; committed beats leave through an output register plus skid.
module feed_pkt_buffer #(
   parameter int DATA_W  = 64,
   parameter int EMPTY_W = 3,
   parameter int DEPTH   = 64,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   output logic               in_ready,
   input  logic               in_valid,
   input  logic               in_startofpacket,
   input  logic               in_endofpacket,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [EMPTY_W-1:0] in_empty,
   input  logic               in_error,
   input  logic               out_ready,
   output logic               out_valid,
   output logic               out_startofpacket,
   output logic               out_endofpacket,
   output logic [DATA_W-1:0]  out_data,
   output logic [EMPTY_W-1:0] out_empty,
   output logic               out_error,
   output logic [CNT_W-1:0]   pkt_count,
   output logic [CNT_W-1:0]   drop_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = DATA_W + EMPTY_W + 1;

   typedef enum logic [1:0] {IDLE, ACCEPT, DISCARD} wr_state_e;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   logic [EW-1:0]    mem_q [DEPTH];
   wr_state_e        state_q, state_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, base;
   logic             orphan_q, orphan_d, in_ready_q;
   logic [CNT_W-1:0] drop_count_q, pkt_count_q;
   logic [1:0]       drop_inc;
   logic             beat, starts, takes, full, wr_en;

   // Write side: a sop always restarts at the last commit point, so an abort needs no extra rollback.
   always_comb begin
      beat        = in_valid & in_ready_q;
      starts      = beat & in_startofpacket;
      takes       = starts | (beat & (state_q == ACCEPT));
      base        = (state_q == ACCEPT && !in_startofpacket) ? wr_ptr_q : wr_commit_q;
      full        = (base - rd_ptr_q) == PW'(DEPTH);
      wr_en       = takes & !full & !in_error;
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      wr_commit_d = wr_commit_q;
      orphan_d    = orphan_q;
      drop_inc    = 2'd0;
      if (starts && state_q == ACCEPT) drop_inc = drop_inc + 2'd1;
      if (starts && orphan_q) begin
         drop_inc = drop_inc + 2'd1;
         orphan_d = 1'b0;
      end
      if (beat && !in_startofpacket && state_q == IDLE) begin
         if (in_endofpacket) begin
            drop_inc = drop_inc + 2'd1;
            orphan_d = 1'b0;
         end else begin
            orphan_d = 1'b1;
         end
      end
      if (takes) begin
         if (!wr_en) begin
            wr_ptr_d = wr_commit_q;
            drop_inc = drop_inc + 2'd1;
            state_d  = in_endofpacket ? IDLE : DISCARD;
         end else begin
            wr_ptr_d = base + PW'(1);
            if (in_endofpacket) begin
               wr_commit_d = base + PW'(1);
               state_d     = IDLE;
            end else begin
               state_d = ACCEPT;
            end
         end
      end else if (beat && state_q == DISCARD && in_endofpacket) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         wr_commit_q  <= '0;
         orphan_q     <= 1'b0;
         in_ready_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         wr_commit_q  <= wr_commit_d;
         orphan_q     <= orphan_d;
         in_ready_q   <= 1'b1;
         drop_count_q <= sat_add(drop_count_q, drop_inc);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[base[AW-1:0]] <= {in_endofpacket, in_empty, in_data};
   end

   // Read side: beat layout is {sop, eop, empty, data}; the skid absorbs the read in flight during a stall.
   logic [EW:0]   out_beat_q, skid_beat_q;
   logic          out_vld_q, skid_vld_q, sop_next_q, rd_en, out_free;
   logic [EW-1:0] rd_entry;

   assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];
   assign rd_en    = (rd_ptr_q != wr_commit_q) & !skid_vld_q;
   assign out_free = !out_vld_q | out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q    <= '0;
         sop_next_q  <= 1'b1;
         out_vld_q   <= 1'b0;
         out_beat_q  <= '0;
         skid_vld_q  <= 1'b0;
         skid_beat_q <= '0;
         pkt_count_q <= '0;
      end else begin
         if (rd_en) begin
            rd_ptr_q   <= rd_ptr_q + PW'(1);
            sop_next_q <= rd_entry[EW-1];
         end
         if (out_free) begin
            if (skid_vld_q) begin
               out_beat_q <= skid_beat_q;
               out_vld_q  <= 1'b1;
               skid_vld_q <= 1'b0;
            end else if (rd_en) begin
               out_beat_q <= {sop_next_q, rd_entry};
               out_vld_q  <= 1'b1;
            end else begin
               out_vld_q <= 1'b0;
            end
         end else if (rd_en) begin
            skid_beat_q <= {sop_next_q, rd_entry};
            skid_vld_q  <= 1'b1;
         end
         if (out_vld_q && out_ready && out_beat_q[EW-1]) pkt_count_q <= pkt_count_q + CNT_W'(1);
      end
   end

   assign in_ready          = in_ready_q;
   assign out_valid         = out_vld_q;
   assign out_startofpacket = out_beat_q[EW];
   assign out_endofpacket   = out_beat_q[EW-1];
   assign out_empty         = out_beat_q[DATA_W +: EMPTY_W];
   assign out_data          = out_beat_q[DATA_W-1:0];
   assign out_error         = 1'b0;
   assign pkt_count         = pkt_count_q;
   assign drop_count        = drop_count_q;
endmodule

// File: doc/feed_pkt_buffer.md
# feed_pkt_buffer

Store-and-forward packet buffer directly upstream of `feed_decoder`, between the MAC receive stream and the decoder input. It accepts 64-bit Avalon-ST beats without backpressure and holds each packet until its final beat arrives. Only complete, error-free packets are released downstream; errored, malformed or overflowing packets are discarded whole. As a result, `feed_decoder` never sees a partial or corrupted frame.

## Interface
Parameters:
- `DATA_W`, 64, beat data width
- `EMPTY_W`, 3, empty-byte count width
- `DEPTH`, 64, buffer depth in beats; power of two, ≥ 4
- `CNT_W`, 16, statistics counter width

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_ready`  out  1  0 during reset; 1 otherwise (never backpressures)
- `in_valid`  in  1  input beat valid
- `in_startofpacket`  in  1  first beat of packet
- `in_endofpacket`  in  1  last beat of packet
- `in_data`  in  DATA_W  beat data
- `in_empty`  in  EMPTY_W  unused bytes on eop beat
- `in_error`  in  1  beat error; marks the whole packet bad
- `out_ready`  in  1  downstream ready
- `out_valid`  out  1  output beat valid
- `out_startofpacket`  out  1  first beat of released packet
- `out_endofpacket`  out  1  last beat of released packet
- `out_data`  out  DATA_W  beat data
- `out_empty`  out  EMPTY_W  empty count; meaningful on eop beat only
- `out_error`  out  1  tied 0
- `pkt_count`  out  CNT_W  packets released; wraps
- `drop_count`  out  CNT_W  packets discarded; saturates at all-ones

## Operation
- Storage: RAM of `DEPTH` entries of {data, eop, empty}. Pointers are log2(DEPTH)+1 bits wide.
- Write pointers:
  - `wr_ptr` is the speculative write pointer.
  - `wr_commit` marks the end of the last good packet.
  - `rd_ptr` is the read pointer.
- Write FSM states are IDLE, ACCEPT and DISCARD.
- IDLE:
  - `in_valid & sop` writes the beat and goes to ACCEPT. If that beat also carries eop, the packet is single-beat and the commit rules apply the same cycle.
  - `in_valid & !sop` is an orphan beat. It is ignored and `drop_count` increments once per orphan run, counted on the orphan's eop beat, or on the next sop if no eop arrives.
- ACCEPT, for each valid beat:
  - If the buffer is full (`wr_ptr - rd_ptr == DEPTH`), the beat is not written and the packet becomes bad.
  - `in_error` on any beat makes the packet bad.
  - A good packet's eop beat is written and `wr_commit <= wr_ptr+1`; the FSM goes to IDLE.
  - A bad packet rolls `wr_ptr <= wr_commit` and `drop_count++`. The FSM goes to IDLE if the beat was eop, otherwise to DISCARD.
  - A sop arriving mid-packet aborts the current packet: rollback and `drop_count++`. The sop beat then starts a new packet.
- DISCARD: valid beats are ignored until eop, then the FSM returns to IDLE. A sop arriving in DISCARD starts a new packet in ACCEPT.
- Read side:
  - Beats are read only while `rd_ptr != wr_commit`.
  - `out_startofpacket` is 1 on the first beat after reset or after a beat with eop.
  - `pkt_count` increments on each accepted beat (`out_valid & out_ready`) that carries eop.
- Packets longer than `DEPTH` beats are always dropped.
- Simultaneous write/commit and read in the same cycle is legal. Full uses `rd_ptr` as registered at the start of the cycle.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, all `out_*` data and flags = 0, counters = 0, all pointers = 0, FSM = IDLE. Reset mid-packet discards all stored and partial data; the discarded packets are not counted.
- `in_ready` goes to 1 in the first cycle after `reset` deasserts.
- Latency: eop of a good packet accepted in cycle N gives the first beat at `out_valid=1` in cycle N+2 (commit register, then registered RAM read), provided the output was empty.
- Output pipeline: output register plus one-entry skid. While `out_valid & !out_ready`, all `out_*` are held stable.
- Throughput: sustains one beat per cycle in and out with `out_ready=1`, with no bubbles between back-to-back committed packets.
- Counters update one cycle after the triggering event.

## Test plan
- Single 3-beat packet (data 0x11, 0x22, 0x33; empty=5 on eop), `out_ready=1` → same 3 beats out, sop on beat 1, eop and empty=5 on beat 3, first `out_valid` 2 cycles after input eop; `pkt_count`=1.
- Packet with `in_error` on beat 2 of 4, followed by a good 2-beat packet → only the 2-beat packet emerges; `drop_count`=1, `pkt_count`=1.
- 70-beat packet with DEPTH=64, then a 2-beat packet → only the 2-beat packet emerges; `drop_count`=1.
- `out_ready`=0 while 4 packets of 8 beats (32 beats) are written, then `out_ready` toggled 1/0 → all 32 beats out in order with stable data during stalls; `pkt_count`=4.
- Sop at beat 3 of an unterminated packet, plus an orphan beat without sop → only the restarted packet emerges; `drop_count`=2.
- Assert `reset` mid-release of a 5-beat packet → `out_valid`=0 in the cycle after reset; nothing is emitted afterwards until a new packet is committed.
